// File: rtl/char_write_arbiter.sv
// char_write_arbiter: merges two character FIFOs round-robin into a rate-limited display write port
// ports: clk, reset_n (async, active-low); a_*/b_* valid-ready character sources;
//        character_id_out + we single-cycle write strobe; busy = FSM active or data queued
module char_write_arbiter #(
  parameter int CHAR_ID_LENGTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_CYCLES = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [CHAR_ID_LENGTH-1:0] a_char,
  input  logic                      a_valid,
  output logic                      a_ready,
  input  logic [CHAR_ID_LENGTH-1:0] b_char,
  input  logic                      b_valid,
  output logic                      b_ready,
  output logic [CHAR_ID_LENGTH-1:0] character_id_out,
  output logic                      we,
  output logic                      busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;
  state_t state;
  logic [GW-1:0] gap;
  logic last_grant;
  logic [1:0][CHAR_ID_LENGTH-1:0] din, head;
  logic [1:0] vld, rdy, ne, push, pop;
  logic take, sel;
  assign din = {b_char, a_char};
  assign vld = {b_valid, a_valid};
  assign push = vld & rdy;
  assign take = state == IDLE && |ne;
  // sel=1 picks B: B when A is empty, or on a tie when A won last time (last_grant=0)
  assign sel = !ne[0] || (ne[1] && !last_grant);
  assign pop = take ? (sel ? 2'b10 : 2'b01) : 2'b00;
  // ready is gated by reset_n only at the port so the FIFO flops never see reset_n as data
  assign a_ready = reset_n & rdy[0];
  assign b_ready = reset_n & rdy[1];
  assign busy = state != IDLE || |ne;
  for (genvar i = 0; i < 2; i++) begin : g_fifo
    logic [CHAR_ID_LENGTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] rp, wp;
    logic [CW-1:0] cnt;
    assign rdy[i] = cnt != CW'(FIFO_DEPTH);
    assign ne[i] = cnt != '0;
    assign head[i] = mem[rp];
    always_ff @(posedge clk)
      if (push[i]) mem[wp] <= din[i];
    always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
        rp <= '0;
        wp <= '0;
        cnt <= '0;
      end else begin
        rp <= rp + AW'(pop[i]);
        wp <= wp + AW'(push[i]);
        cnt <= cnt + CW'(push[i]) - CW'(pop[i]);
      end
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      we <= 1'b0;
      character_id_out <= '0;
      gap <= '0;
      last_grant <= 1'b1;
    end else
      case (state)
        IDLE: if (take) begin
          state <= ISSUE;
          we <= 1'b1;
          character_id_out <= head[sel];
          last_grant <= sel;
        end
        ISSUE: begin
          state <= GAP;
          we <= 1'b0;
          gap <= GW'(GAP_CYCLES - 1);
        end
        default: if (gap == '0) state <= IDLE; else gap <= gap - GW'(1);
      endcase
endmodule

// File: tb/tb_char_write_arbiter.sv
// tb_char_write_arbiter: queue-based reference model plus directed scenarios for char_write_arbiter
module tb_char_write_arbiter;
  localparam int W = 8, D = 4, G = 4;
  logic clk = 0, reset_n = 0;
  logic [W-1:0] a_char = 0, b_char = 0;
  logic a_valid = 0, b_valid = 0;
  logic a_ready, b_ready, we, busy;
  logic [W-1:0] character_id_out;
  char_write_arbiter #(.CHAR_ID_LENGTH(W), .FIFO_DEPTH(D), .GAP_CYCLES(G)) dut (
    .clk(clk), .reset_n(reset_n),
    .a_char(a_char), .a_valid(a_valid), .a_ready(a_ready),
    .b_char(b_char), .b_valid(b_valid), .b_ready(b_ready),
    .character_id_out(character_id_out), .we(we), .busy(busy)
  );
  always #5 clk = ~clk;
  int checks = 0, errors = 0, cyc = 0;
  logic [W-1:0] qa[$], qb[$];
  int last = -100000;
  bit last_a = 0;
  logic m_we = 0;
  logic [W-1:0] m_char = 0;
  int pe[$];
  logic [W-1:0] pc[$];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask
  // model: a write may start only when 6 edges have passed since the previous one;
  // ties go to the source that was not served last; pushes use pre-edge occupancy
  always @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      qa.delete(); qb.delete();
      last = -100000; last_a = 0; m_we = 0; m_char = 0;
    end else begin
      bit pa, pb, ta;
      cyc++;
      pa = a_valid && qa.size() < D;
      pb = b_valid && qb.size() < D;
      m_we = 0;
      if (cyc - last >= G + 2 && (qa.size() > 0 || qb.size() > 0)) begin
        ta = qa.size() > 0 && (qb.size() == 0 || !last_a);
        m_char = ta ? qa.pop_front() : qb.pop_front();
        last_a = ta; last = cyc; m_we = 1;
      end
      if (pa) qa.push_back(a_char);
      if (pb) qb.push_back(b_char);
    end
  always @(negedge clk) begin
    chk("we", we, m_we);
    chk("char", character_id_out, m_char);
    chk("a_ready", a_ready, reset_n && qa.size() < D);
    chk("b_ready", b_ready, reset_n && qb.size() < D);
    chk("busy", busy, reset_n && (qa.size() > 0 || qb.size() > 0 || cyc - last < G + 1));
    if (reset_n && we) begin
      pe.push_back(cyc);
      pc.push_back(character_id_out);
    end
  end
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic push_a(input logic [W-1:0] c, output int waits, output int ae);
    a_char = c; a_valid = 1; waits = 0;
    while (!a_ready && waits < 100) begin @(negedge clk); waits++; end
    if (waits >= 100) begin errors++; $display("FAIL push_a timeout char %0h", c); end
    ae = cyc + 1;
    @(negedge clk);
    a_valid = 0;
  endtask
  task automatic push_b(input logic [W-1:0] c, output int waits, output int ae);
    b_char = c; b_valid = 1; waits = 0;
    while (!b_ready && waits < 100) begin @(negedge clk); waits++; end
    if (waits >= 100) begin errors++; $display("FAIL push_b timeout char %0h", c); end
    ae = cyc + 1;
    @(negedge clk);
    b_valid = 0;
  endtask
  task automatic do_reset();
    #2 reset_n = 0; a_valid = 0; b_valid = 0;
    #1 chk("rst_we", we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_a_ready", a_ready, 0);
    chk("rst_b_ready", b_ready, 0);
    chk("rst_char", character_id_out, 0);
    repeat (2) @(negedge clk);
    #2 reset_n = 1;
    #1 pe.delete(); pc.delete();
  endtask
  initial begin
    #100000 $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    int w, e, wb, eb, c0, n, seen;
    logic [W-1:0] tie_exp [4];
    logic [W-1:0] sub[$];
    tie_exp = '{8'h41, 8'h61, 8'h42, 8'h62};
    repeat (2) @(negedge clk);
    do_reset();
    c0 = cyc;
    push_a(8'h41, w, e);
    idle(14);
    chk("single_first_edge", e, c0 + 1);
    chk("single_count", pe.size(), 1);
    chk("single_char", pc[0], 8'h41);
    chk("single_latency", pe[0], e + 1);
    @(negedge clk);
    do_reset();
    fork
      begin push_a(8'h41, w, e); push_a(8'h42, w, e); end
      begin push_b(8'h61, wb, eb); push_b(8'h62, wb, eb); end
    join
    idle(30);
    chk("tie_count", pe.size(), 4);
    for (int i = 0; i < 4; i++) chk("tie_order", pc[i], tie_exp[i]);
    for (int i = 1; i < 4; i++) chk("tie_spacing", pe[i] - pe[i-1], 6);
    do_reset();
    push_b(8'h70, wb, eb);
    fork
      begin
        for (int i = 0; i < 4; i++) push_a(8'h10 + 8'(i), w, e);
        chk("full_a_ready", a_ready, 0);
        push_a(8'h14, w, e);
        chk("full_held", w > 0, 1);
      end
      begin push_b(8'h71, wb, eb); push_b(8'h72, wb, eb); end
    join
    idle(60);
    chk("full_count", pe.size(), 8);
    sub.delete();
    foreach (pc[i]) if (pc[i][7:4] == 4'h1) sub.push_back(pc[i]);
    chk("full_a_count", sub.size(), 5);
    for (int i = 0; i < 5; i++) chk("full_a_order", sub[i], 8'h10 + 8'(i));
    do_reset();
    push_b(8'h80, wb, eb);
    push_a(8'h21, w, e);
    push_a(8'h22, w, e);
    idle(4);
    push_a(8'h23, w, c0);
    push_a(8'h24, w, e);
    push_a(8'h25, w, e);
    chk("pushpop_a_ready", a_ready, 0);
    idle(40);
    chk("pushpop_count", pe.size(), 6);
    chk("pushpop_same_edge", pe[1], c0);
    for (int i = 0; i < 5; i++) chk("pushpop_order", pc[i+1], 8'h21 + 8'(i));
    do_reset();
    for (int i = 0; i < 5; i++) push_a(8'h30 + 8'(i), w, e);
    seen = 0;
    for (n = 0; n < 50 && seen < 2; n++) begin
      @(negedge clk);
      #1 if (we) seen++;
    end
    chk("mid_found_issue", seen, 2);
    do_reset();
    idle(30);
    chk("mid_no_stale", pe.size(), 0);
    chk("mid_busy", busy, 0);
    chk("mid_a_ready", a_ready, 1);
    chk("mid_b_ready", b_ready, 1);
    @(negedge clk);
    do_reset();
    for (int i = 0; i < 12; i++) push_a(8'hA0 + 8'(i), w, e);
    idle(80);
    chk("wrap_count", pe.size(), 12);
    for (int i = 0; i < 12; i++) chk("wrap_order", pc[i], 8'hA0 + 8'(i));
    for (int i = 1; i < 12; i++) chk("wrap_spacing", pe[i] - pe[i-1] >= 6, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
